// File: rtl/frame_crop_pkg.sv
// Shared read-FSM state type and default source/crop geometry for the frame crop buffer.
package frame_crop_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StStream,
        StRelease
    } rdState_e;

    localparam int unsigned DefDataW     = 8;
    localparam int unsigned DefDepth     = 36300;
    localparam int unsigned DefHdrOffset = 3330;
    localparam int unsigned DefSrcStride = 330;
    localparam int unsigned DefCropW     = 300;
    localparam int unsigned DefCropH     = 100;

    // One past the highest source index touched by the crop window.
    function automatic int unsigned cropSpan(input int unsigned hdrOffset,
                                             input int unsigned srcStride,
                                             input int unsigned cropW,
                                             input int unsigned cropH);
        return hdrOffset + (cropH - 1) * srcStride + cropW;
    endfunction

endpackage

// File: rtl/fc_bank_ram.sv
// Two-bank simple dual-port byte store: one write port, one synchronous read port (1-cycle latency).
module fc_bank_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 36300,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic              wrBank,
    input  logic [ADDR_W-1:0] wrIdx,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic              rdBank,
    input  logic [ADDR_W-1:0] rdIdx,
    output logic [DATA_W-1:0] rdData
);

    localparam int unsigned Entries = 2 * DEPTH;
    localparam int unsigned LinW    = $clog2(Entries);

    logic [DATA_W-1:0] mem [Entries];
    logic [LinW-1:0]   wrLin;
    logic [LinW-1:0]   rdLin;

    // Bank 1 occupies the upper DEPTH entries, so no storage is wasted when DEPTH is not a power of 2.
    assign wrLin = LinW'(wrIdx) + (wrBank ? LinW'(DEPTH) : LinW'(0));
    assign rdLin = LinW'(rdIdx) + (rdBank ? LinW'(DEPTH) : LinW'(0));

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrLin] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rdEn) begin
            rdData <= mem[rdLin];
        end
    end

endmodule

// File: rtl/frame_crop_buffer.sv
// Double-buffered frame store: captures raw source frames into two banks and streams a cropped
// window from the oldest complete bank through a 2-entry skid buffer.
module frame_crop_buffer
    import frame_crop_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned HDR_OFFSET = DefHdrOffset,
    parameter int unsigned SRC_STRIDE = DefSrcStride,
    parameter int unsigned CROP_W     = DefCropW,
    parameter int unsigned CROP_H     = DefCropH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sol,
    output logic              out_last,
    output logic [1:0]        bank_full,
    output logic              busy
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    if (cropSpan(HDR_OFFSET, SRC_STRIDE, CROP_W, CROP_H) > DEPTH) begin : gBadGeometry
        $error("frame_crop_buffer: crop window does not fit inside DEPTH");
    end

    // ---------------- write side ----------------
    logic [ADDR_W-1:0] wrIdxQ, wrIdxD;
    logic              wrBankQ, wrBankD;
    logic [1:0]        fullQ, fullD;
    logic              wrFire, wrLast, setFull, clrFull;

    // ---------------- read side ----------------
    rdState_e          stateQ, stateD;
    logic              rdBankQ, rdBankD;
    logic [ADDR_W-1:0] lineBaseQ, lineBaseD;
    logic [ADDR_W-1:0] colQ, colD;
    logic [ADDR_W-1:0] rowQ, rowD;
    logic              issuedQ, issuedD;
    logic              colEnd, rowEnd, space, issue, pop;
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] ramData;
    logic              rdValidQ, solPipeQ, lastPipeQ;

    // ---------------- skid buffer ----------------
    logic [1:0]        skidCntQ, skidCntD, occ;
    logic [DATA_W-1:0] headDataQ, headDataD, spareDataQ, spareDataD;
    logic              headSolQ, headSolD, spareSolQ, spareSolD;
    logic              headLastQ, headLastD, spareLastQ, spareLastD;

    assign wr_ready  = !fullQ[wrBankQ];
    assign wrFire    = wr_valid && wr_ready;
    assign wrLast    = wrIdxQ == ADDR_W'(DEPTH - 1);
    assign setFull   = wrFire && wrLast;
    assign clrFull   = stateQ == StRelease;
    assign bank_full = fullQ;

    always_comb begin
        wrIdxD  = wrIdxQ;
        wrBankD = wrBankQ;
        fullD   = fullQ;
        if (wrFire) begin
            if (wrLast) begin
                wrIdxD  = '0;
                wrBankD = !wrBankQ;
            end else begin
                wrIdxD = wrIdxQ + ADDR_W'(1);
            end
        end
        // Completion and release always target different banks, so both updates apply.
        if (setFull) fullD[wrBankQ] = 1'b1;
        if (clrFull) fullD[rdBankQ] = 1'b0;
    end

    assign colEnd = colQ == ADDR_W'(CROP_W - 1);
    assign rowEnd = rowQ == ADDR_W'(CROP_H - 1);
    assign rdAddr = lineBaseQ + colQ;

    assign out_valid = skidCntQ != 2'd0;
    assign pop       = out_valid && out_ready;
    assign out_data  = headDataQ;
    assign out_sol   = headSolQ && out_valid;
    assign out_last  = headLastQ && out_valid;
    assign busy      = stateQ != StIdle;

    // Buffered beats plus the one possibly in flight in the RAM must never exceed two.
    assign occ   = skidCntQ + {1'b0, rdValidQ};
    assign space = (occ < 2'd2) || pop;
    assign issue = (stateQ == StStream) && !issuedQ && space;

    always_comb begin
        stateD    = stateQ;
        rdBankD   = rdBankQ;
        lineBaseD = lineBaseQ;
        colD      = colQ;
        rowD      = rowQ;
        issuedD   = issuedQ;
        case (stateQ)
            StIdle: begin
                if (rd_start) stateD = StWait;
            end
            StWait: begin
                if (fullQ[rdBankQ]) begin
                    lineBaseD = ADDR_W'(HDR_OFFSET);
                    colD      = '0;
                    rowD      = '0;
                    issuedD   = 1'b0;
                    stateD    = StStream;
                end
            end
            StStream: begin
                if (issue) begin
                    if (colEnd) begin
                        colD = '0;
                        if (rowEnd) begin
                            issuedD = 1'b1;
                        end else begin
                            rowD      = rowQ + ADDR_W'(1);
                            lineBaseD = lineBaseQ + ADDR_W'(SRC_STRIDE);
                        end
                    end else begin
                        colD = colQ + ADDR_W'(1);
                    end
                end
                if (pop && headLastQ) stateD = StRelease;
            end
            StRelease: begin
                rdBankD = !rdBankQ;
                stateD  = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        skidCntD   = skidCntQ;
        headDataD  = headDataQ;
        headSolD   = headSolQ;
        headLastD  = headLastQ;
        spareDataD = spareDataQ;
        spareSolD  = spareSolQ;
        spareLastD = spareLastQ;
        case ({rdValidQ, pop})
            2'b10: begin
                if (skidCntQ == 2'd0) begin
                    headDataD = ramData;
                    headSolD  = solPipeQ;
                    headLastD = lastPipeQ;
                end else begin
                    spareDataD = ramData;
                    spareSolD  = solPipeQ;
                    spareLastD = lastPipeQ;
                end
                skidCntD = skidCntQ + 2'd1;
            end
            2'b01: begin
                if (skidCntQ == 2'd2) begin
                    headDataD = spareDataQ;
                    headSolD  = spareSolQ;
                    headLastD = spareLastQ;
                end
                skidCntD = skidCntQ - 2'd1;
            end
            2'b11: begin
                if (skidCntQ == 2'd1) begin
                    headDataD = ramData;
                    headSolD  = solPipeQ;
                    headLastD = lastPipeQ;
                end else begin
                    headDataD  = spareDataQ;
                    headSolD   = spareSolQ;
                    headLastD  = spareLastQ;
                    spareDataD = ramData;
                    spareSolD  = solPipeQ;
                    spareLastD = lastPipeQ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrIdxQ     <= '0;
            wrBankQ    <= 1'b0;
            fullQ      <= 2'b00;
            stateQ     <= StIdle;
            rdBankQ    <= 1'b0;
            lineBaseQ  <= '0;
            colQ       <= '0;
            rowQ       <= '0;
            issuedQ    <= 1'b0;
            rdValidQ   <= 1'b0;
            solPipeQ   <= 1'b0;
            lastPipeQ  <= 1'b0;
            skidCntQ   <= 2'd0;
            headDataQ  <= '0;
            headSolQ   <= 1'b0;
            headLastQ  <= 1'b0;
            spareDataQ <= '0;
            spareSolQ  <= 1'b0;
            spareLastQ <= 1'b0;
        end else begin
            wrIdxQ     <= wrIdxD;
            wrBankQ    <= wrBankD;
            fullQ      <= fullD;
            stateQ     <= stateD;
            rdBankQ    <= rdBankD;
            lineBaseQ  <= lineBaseD;
            colQ       <= colD;
            rowQ       <= rowD;
            issuedQ    <= issuedD;
            rdValidQ   <= issue;
            solPipeQ   <= colQ == '0;
            lastPipeQ  <= colEnd && rowEnd;
            skidCntQ   <= skidCntD;
            headDataQ  <= headDataD;
            headSolQ   <= headSolD;
            headLastQ  <= headLastD;
            spareDataQ <= spareDataD;
            spareSolQ  <= spareSolD;
            spareLastQ <= spareLastD;
        end
    end

    fc_bank_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) uRam (
        .clk   (clk),
        .wrEn  (wrFire),
        .wrBank(wrBankQ),
        .wrIdx (wrIdxQ),
        .wrData(wr_data),
        .rdEn  (issue),
        .rdBank(rdBankQ),
        .rdIdx (rdAddr),
        .rdData(ramData)
    );

    aSameBankSetClr: assert property (@(posedge clk) disable iff (reset)
        !(setFull && clrFull && (wrBankQ == rdBankQ)));

endmodule

// File: tb/tb_frame_crop_buffer.sv
// Self-checking bench for frame_crop_buffer on a reduced geometry: scoreboard of expected beats
// plus a table of hand-derived probe beats.
module tb_frame_crop_buffer;

    localparam int unsigned TbDepth  = 120;
    localparam int unsigned TbHdr    = 10;
    localparam int unsigned TbStride = 12;
    localparam int unsigned TbCropW  = 8;
    localparam int unsigned TbCropH  = 9;
    localparam int          Beats    = TbCropW * TbCropH;

    typedef struct {
        logic [7:0] data;
        logic       sol;
        logic       last;
    } beat_t;

    typedef struct {
        int         beat;
        logic [7:0] data;
        logic       sol;
        logic       last;
    } probe_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_start = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_sol;
    logic       out_last;
    logic [1:0] bank_full;
    logic       busy;

    int    total = 0;
    int    bad = 0;
    int    beatCnt = 0;
    bit    readyMode = 1'b0;
    beat_t expQ[$];
    beat_t beatLog[$];
    probe_t probes[6];

    logic       prevStall = 1'b0;
    logic [7:0] prevData;
    logic       prevSol, prevLast;

    frame_crop_buffer #(
        .DATA_W    (8),
        .DEPTH     (TbDepth),
        .HDR_OFFSET(TbHdr),
        .SRC_STRIDE(TbStride),
        .CROP_W    (TbCropW),
        .CROP_H    (TbCropH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_start (rd_start),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sol  (out_sol),
        .out_last (out_last),
        .bank_full(bank_full),
        .busy     (busy)
    );

    always #5 clk = !clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic logic [7:0] byteOf(input int seed, input int idx);
        return 8'(idx + seed * 37);
    endfunction

    // Expected crop of frame 'seed', queued when its readout is requested.
    task automatic pushFrame(input int seed);
        beat_t b;
        for (int r = 0; r < int'(TbCropH); r++) begin
            for (int c = 0; c < int'(TbCropW); c++) begin
                b.data = byteOf(seed, TbHdr + r * TbStride + c);
                b.sol  = (c == 0);
                b.last = (r == TbCropH - 1) && (c == TbCropW - 1);
                expQ.push_back(b);
            end
        end
    endtask

    task automatic writeByte(input logic [7:0] d, output bit ok);
        int guard = 0;
        ok = 1'b0;
        wr_valid = 1'b1;
        wr_data  = d;
        forever begin
            @(negedge clk);
            if (wr_ready) break;
            guard++;
            if (guard > 2000) begin
                wr_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic writeFrame(input int seed, input int count);
        bit ok;
        for (int i = 0; i < count; i++) begin
            writeByte(byteOf(seed, i), ok);
            if (!ok) begin
                failNow("write_stalled");
                return;
            end
        end
    endtask

    task automatic startRead(input int seed);
        pushFrame(seed);
        rd_start = 1'b1;
        @(posedge clk);
        #1;
        rd_start = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) failNow({name, "_drain"});
    endtask

    task automatic doReset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        rd_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
    endtask

    task automatic checkProbes(input string tag);
        for (int i = 0; i < 6; i++) begin
            if (probes[i].beat >= beatLog.size()) begin
                failNow({tag, "_probe_missing"});
            end else begin
                check({tag, "_probe_data"}, beatLog[probes[i].beat].data, probes[i].data);
                check({tag, "_probe_sol"}, beatLog[probes[i].beat].sol, probes[i].sol);
                check({tag, "_probe_last"}, beatLog[probes[i].beat].last, probes[i].last);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = readyMode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", {out_data, out_sol, out_last}, {prevData, prevSol, prevLast});
            end
            if (out_valid && out_ready) begin
                beatCnt++;
                beatLog.push_back('{out_data, out_sol, out_last});
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat actual=%0h required=none", out_data);
                end else begin
                    e = expQ.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_sol", 32'(out_sol), 32'(e.sol));
                    check("beat_last", 32'(out_last), 32'(e.last));
                end
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevSol   = out_sol;
            prevLast  = out_last;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int fires;

        // Hand-derived beats of seed-0 frame: index = 10 + row*12 + col.
        probes[0] = '{0,  8'h0A, 1'b1, 1'b0};
        probes[1] = '{5,  8'h0F, 1'b0, 1'b0};
        probes[2] = '{8,  8'h16, 1'b1, 1'b0};
        probes[3] = '{17, 8'h23, 1'b0, 1'b0};
        probes[4] = '{64, 8'h6A, 1'b1, 1'b0};
        probes[5] = '{71, 8'h71, 1'b0, 1'b1};

        doReset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sol", 32'(out_sol), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_bank_full", bank_full, 32'd0);

        // Basic capture and readout.
        beatLog.delete();
        writeFrame(0, TbDepth);
        check("s1_full_after_write", bank_full, 32'b01);
        base = beatCnt;
        startRead(0);
        waitDrain("s1");
        check("s1_beats", beatCnt - base, Beats);
        check("s1_full_after_read", bank_full, 32'b00);
        checkProbes("s1");

        // Both banks full: writer stalls.
        writeFrame(1, TbDepth);
        writeFrame(2, TbDepth);
        check("s2_full", bank_full, 32'b11);
        check("s2_wr_ready", 32'(wr_ready), 32'd0);
        fires = 0;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_ready) fires++;
        end
        wr_valid = 1'b0;
        check("s2_stalled_fires", fires, 32'd0);
        startRead(1);
        waitDrain("s2a");
        startRead(2);
        waitDrain("s2b");
        check("s2_full_after", bank_full, 32'b00);

        // Readout overlapping capture of the next frame.
        writeFrame(4, TbDepth);
        startRead(4);
        fork
            writeFrame(5, TbDepth);
            waitDrain("s3a");
        join
        check("s3_full_mid", bank_full, 32'b01);
        startRead(5);
        waitDrain("s3b");
        check("s3_full_after", bank_full, 32'b00);

        // Backpressure at 30% ready.
        readyMode = 1'b1;
        beatLog.delete();
        writeFrame(0, TbDepth);
        startRead(0);
        waitDrain("s4");
        readyMode = 1'b0;
        @(posedge clk);
        #1;
        checkProbes("s4");
        check("s4_beats", beatLog.size(), Beats);

        // Read requested before any data is present.
        startRead(9);
        repeat (5) @(posedge clk);
        #1;
        check("s5_busy_waiting", 32'(busy), 32'd1);
        check("s5_no_valid", 32'(out_valid), 32'd0);
        writeFrame(9, TbDepth);
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (out_valid) break;
        end
        check("s5_latency", k, 32'd3);
        waitDrain("s5");

        // Reset halfway through a readout with a partial frame pending.
        writeFrame(6, TbDepth);
        writeFrame(7, 30);
        base = beatCnt;
        startRead(6);
        k = 0;
        while (beatCnt < base + Beats / 2 && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 2000) failNow("s6_reach_mid");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("s6_out_valid", 32'(out_valid), 32'd0);
        check("s6_bank_full", bank_full, 32'd0);
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_wr_ready", 32'(wr_ready), 32'd1);
        reset = 1'b0;
        expQ.delete();
        writeFrame(8, TbDepth);
        check("s6_full_bank0", bank_full, 32'b01);
        base = beatCnt;
        startRead(8);
        waitDrain("s6");
        check("s6_beats", beatCnt - base, Beats);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
